ldtu_ofifo_drain_ctrl: RTL

Read-side sequencer for the LiTe-DTU Hamming output storage FIFO. It issues single-cycle read requests into the FIFO, collects the decoded 32-bit word from the downstream Hamming decoder, and presents it on a valid/ready output port toward the serializer. When the FIFO is empty it fills the stream with idle words, and after every frame of data words it inserts a trailer word. It also tracks decoder errors and read timeouts.

---
 rtl/ldtu_drain_pkg.sv | 25 ++
 rtl/ldtu_drain_outreg.sv | 43 ++++
 rtl/ldtu_ofifo_drain_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ldtu_drain_pkg.sv
// Shared types and constants for the LiTe-DTU output FIFO drain sequencer.
package ldtu_drain_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        SEND,
        TRAILER
    } drain_state_e;

    localparam logic [3:0]  TRAILER_TAG = 4'hD;
    localparam int unsigned FRAME_CNT_W = 12;
    localparam int unsigned ERR_CNT_W   = 8;
    localparam int unsigned WORD_CNT_W  = 8;

    function automatic logic [31:0] make_trailer(
        input logic [FRAME_CNT_W-1:0] frame_cnt,
        input logic [ERR_CNT_W-1:0]   err_cnt,
        input logic [7:0]             frame_len
    );
        return {TRAILER_TAG, frame_cnt, err_cnt, frame_len};
    endfunction

endpackage

// File: rtl/ldtu_drain_outreg.sv
// Valid/ready output register; holds out_data stable while the consumer stalls.
module ldtu_drain_outreg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         free
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;

    assign free      = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load && free) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/ldtu_ofifo_drain_ctrl.sv
// Read-side sequencer for the LiTe-DTU Hamming output FIFO: read, decode capture, idle fill.
// Frame trailers with word/frame counters are built only when LDTU_TRAILER_EN is defined.
module ldtu_ofifo_drain_ctrl
    import ldtu_drain_pkg::*;
#(
    parameter int unsigned          NBITS_OUT    = 32,
    parameter int unsigned          FRAME_LEN    = 50,
    parameter int unsigned          RD_TIMEOUT   = 4,
    parameter logic [NBITS_OUT-1:0] IDLE_PATTERN = 32'hEAAAAAAA
) (
    input  logic                 CLK,
    input  logic                 rst_b,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    input  logic                 dec_valid,
    input  logic [NBITS_OUT-1:0] dec_data,
    input  logic                 dec_err,
    output logic [NBITS_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [7:0]           err_cnt
);

    drain_state_e         state_q, state_d;
    logic                 fifo_rd_q, fifo_rd_d;
    logic [NBITS_OUT-1:0] hold_q, hold_d;
    logic [3:0]           tmo_cnt_q, tmo_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 timeout_err_q, timeout_err_d;
`ifdef LDTU_TRAILER_EN
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

    logic                 load;
    logic [NBITS_OUT-1:0] load_data;
    logic                 out_free;
    logic                 tmo_expired;

    assign tmo_expired = (tmo_cnt_q == 4'(RD_TIMEOUT - 1));

    ldtu_drain_outreg #(
        .W(NBITS_OUT)
    ) u_outreg (
        .clk       (CLK),
        .rst_n     (rst_b),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .free      (out_free)
    );

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
`ifdef LDTU_TRAILER_EN
                if (word_cnt_q == WORD_CNT_W'(FRAME_LEN)) begin
                    state_d = TRAILER;
                end else
`endif
                if (!fifo_empty) begin
                    state_d = REQ;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (dec_valid) begin
                    state_d = SEND;
                end else if (tmo_expired) begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (out_free) begin
                    state_d = IDLE;
                end
            end
`ifdef LDTU_TRAILER_EN
            TRAILER: begin
                if (out_free) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // fifo_rd is registered from the next state so it coincides with the REQ cycle
    always_comb begin
        fifo_rd_d     = (state_d == REQ);
        load          = 1'b0;
        load_data     = hold_q;
        hold_d        = hold_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_cnt_d     = err_cnt_q;
        timeout_err_d = timeout_err_q;
`ifdef LDTU_TRAILER_EN
        word_cnt_d    = word_cnt_q;
        frame_cnt_d   = frame_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (state_d == IDLE && out_free) begin
                    load      = 1'b1;
                    load_data = IDLE_PATTERN;
                end
            end
            REQ: tmo_cnt_d = '0;
            WAIT: begin
                if (dec_valid) begin
                    hold_d = dec_data;
                    if (dec_err && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end else if (tmo_expired) begin
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (out_free) begin
                    load = 1'b1;
`ifdef LDTU_TRAILER_EN
                    word_cnt_d = word_cnt_q + 1'b1;
`endif
                end
            end
`ifdef LDTU_TRAILER_EN
            TRAILER: begin
                if (out_free) begin
                    load        = 1'b1;
                    load_data   = NBITS_OUT'(make_trailer(frame_cnt_q, err_cnt_q, 8'(FRAME_LEN)));
                    word_cnt_d  = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            fifo_rd_q     <= 1'b0;
            hold_q        <= '0;
            tmo_cnt_q     <= '0;
            err_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
`ifdef LDTU_TRAILER_EN
            word_cnt_q    <= '0;
            frame_cnt_q   <= '0;
`endif
        end else begin
            fifo_rd_q     <= fifo_rd_d;
            hold_q        <= hold_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_cnt_q     <= err_cnt_d;
            timeout_err_q <= timeout_err_d;
`ifdef LDTU_TRAILER_EN
            word_cnt_q    <= word_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign fifo_rd     = fifo_rd_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;
    assign err_cnt     = err_cnt_q;

endmodule
